// File: rtl/axi_lite_master_pkg.sv
// Shared constants and FSM state type for the AXI-Lite request bridge.
package axi_lite_master_pkg;

    localparam int unsigned CPU_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_B = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

endpackage

// File: rtl/axi_lite_master_stdreg.sv
// Enabled register with asynchronous active-low reset to a fixed value.
module axi_lite_master_stdreg #(
    parameter int unsigned W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding core request port to AXI-Lite initiator (AR/R or AW+W/B per request).
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_WIDTH,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [DATA_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [STRB_W-1:0] i_req_wstrb,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [DATA_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    state_t              state_q, state_d;
    logic [2:0]          state_raw_q;
    logic                pay_en;
    logic [DATA_W-1:0]   addr_q, wdata_q, rdata_q, rdata_d;
    logic [STRB_W-1:0]   wstrb_q;
    logic                err_q, err_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;

    axi_lite_master_stdreg #(.W(3), .RST_VAL(3'(ST_IDLE))) u_state (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(1'b1), .i_d(state_d), .o_q(state_raw_q)
    );
    assign state_q = state_t'(state_raw_q);

    axi_lite_master_stdreg #(.W(DATA_W)) u_addr (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(pay_en), .i_d(i_req_addr), .o_q(addr_q)
    );
    axi_lite_master_stdreg #(.W(DATA_W)) u_wdata (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(pay_en), .i_d(i_req_wdata), .o_q(wdata_q)
    );
    axi_lite_master_stdreg #(.W(STRB_W)) u_wstrb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(pay_en), .i_d(i_req_wstrb), .o_q(wstrb_q)
    );
    axi_lite_master_stdreg #(.W(DATA_W + 1)) u_rsp (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(1'b1),
        .i_d({rdata_d, err_d}), .o_q({rdata_q, err_q})
    );
    axi_lite_master_stdreg #(.W(2)) u_done (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(1'b1),
        .i_d({aw_done_d, w_done_d}), .o_q({aw_done_q, w_done_q})
    );

    always_comb begin
        state_d   = state_q;
        pay_en    = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    pay_en  = 1'b1;
                    state_d = i_req_wen ? ST_WR_A : ST_RD_A;
                end
            end
            ST_RD_A: if (arready) state_d = ST_RD_D;
            ST_RD_D: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = (rresp != AXI_RESP_OKAY);
                    state_d = ST_RSP;
                end
            end
            ST_WR_A: begin
                // A channel whose flag is already set has VALID low, so OR-ing READY is a no-op there.
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (bvalid) begin
                    rdata_d = '0;
                    err_d   = (bresp != AXI_RESP_OKAY);
                    state_d = ST_RSP;
                end
            end
            ST_RSP:  if (i_rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state_q == ST_IDLE);
        arvalid     = (state_q == ST_RD_A);
        rready      = (state_q == ST_RD_D);
        awvalid     = (state_q == ST_WR_A) && !aw_done_q;
        wvalid      = (state_q == ST_WR_A) && !w_done_q;
        bready      = (state_q == ST_WR_B);
        o_rsp_valid = (state_q == ST_RSP);
    end

    assign araddr      = addr_q;
    assign awaddr      = addr_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: bench-driven AXI-Lite responder plus a transaction-level reference model.
module tb_axi_lite_master;
    import axi_lite_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0, i_req_wen = 1'b0, i_rsp_ready = 1'b0;
    logic [31:0] i_req_addr = '0, i_req_wdata = '0;
    logic [3:0]  i_req_wstrb = '0;
    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_master #(.DATA_W(32), .STRB_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase flags of the one outstanding request, advanced by predicted handshakes.
    bit          m_busy, m_wen, m_ar, m_aw, m_w, m_dat, m_rsp, m_err;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [3:0]  m_wstrb;

    always @(negedge clk) begin
        bit e_arv, e_awv, e_wv, e_rr, e_br;
        bit f_acc, f_ar, f_aw, f_w, f_r, f_b, f_rsp;
        if (!rst_n) begin
            m_busy = 0; m_ar = 0; m_aw = 0; m_w = 0; m_dat = 0; m_rsp = 0;
            chk("reset_ctrl", {25'd0, o_req_ready, arvalid, awvalid, wvalid, rready, bready, o_rsp_valid},
                32'h40);
            chk("reset_payload", araddr | awaddr | wdata | {28'd0, wstrb} | o_rsp_rdata, 32'd0);
            chk("reset_err", {31'd0, o_rsp_err}, 32'd0);
        end else begin
            e_arv = m_busy && !m_wen && m_ar;
            e_awv = m_busy && m_wen && m_aw;
            e_wv  = m_busy && m_wen && m_w;
            e_rr  = m_busy && !m_wen && !m_ar && m_dat;
            e_br  = m_busy && m_wen && !m_aw && !m_w && m_dat;
            chk("req_ready", {31'd0, o_req_ready}, {31'd0, !m_busy});
            chk("arvalid", {31'd0, arvalid}, {31'd0, e_arv});
            chk("awvalid", {31'd0, awvalid}, {31'd0, e_awv});
            chk("wvalid", {31'd0, wvalid}, {31'd0, e_wv});
            chk("rready", {31'd0, rready}, {31'd0, e_rr});
            chk("bready", {31'd0, bready}, {31'd0, e_br});
            chk("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, m_rsp});
            if (e_arv) chk("araddr", araddr, m_addr);
            if (e_awv) chk("awaddr", awaddr, m_addr);
            if (e_wv) begin
                chk("wdata", wdata, m_wdata);
                chk("wstrb", {28'd0, wstrb}, {28'd0, m_wstrb});
            end
            if (m_rsp) begin
                chk("rsp_rdata", o_rsp_rdata, m_rd);
                chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, m_err});
            end
            f_acc = !m_busy && i_req_valid;
            f_ar  = e_arv && arready;
            f_aw  = e_awv && awready;
            f_w   = e_wv && wready;
            f_r   = e_rr && rvalid;
            f_b   = e_br && bvalid;
            f_rsp = m_rsp && i_rsp_ready;
            if (f_acc) begin
                m_busy = 1; m_wen = i_req_wen; m_addr = i_req_addr;
                m_wdata = i_req_wdata; m_wstrb = i_req_wstrb;
                m_ar = !i_req_wen; m_aw = i_req_wen; m_w = i_req_wen; m_dat = 1; m_rsp = 0;
            end
            if (f_ar) m_ar = 0;
            if (f_aw) m_aw = 0;
            if (f_w) m_w = 0;
            if (f_r) begin m_rd = rdata; m_err = (rresp != 2'b00); m_dat = 0; m_rsp = 1; end
            if (f_b) begin m_rd = '0; m_err = (bresp != 2'b00); m_dat = 0; m_rsp = 1; end
            if (f_rsp) begin m_rsp = 0; m_busy = 0; end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Responder: address READYs after a_dly/w_dly cycles, R/B VALID d_dly cycles after the address phase.
    task automatic do_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int unsigned a_dly, input int unsigned w_dly,
                          input int unsigned d_dly, input int unsigned r_dly,
                          input logic [31:0] rd, input logic [1:0] resp, input bit stray,
                          output logic [31:0] got_rd, output logic got_err, output logic first_v);
        int unsigned c, d_cnt;
        bit a_done, w_done, ph;
        c = 0;
        while (!o_req_ready && c < 50) begin step(); c++; end
        i_req_valid = 1; i_req_wen = wen; i_req_addr = addr; i_req_wdata = wd; i_req_wstrb = ws;
        step();
        i_req_valid = 0; i_req_addr = $urandom; i_req_wdata = $urandom; i_req_wstrb = 4'($urandom);
        first_v = wen ? (awvalid && wvalid) : arvalid;
        c = 0; d_cnt = 0; a_done = 0; w_done = !wen;
        while (!o_rsp_valid && c < 200) begin
            ph = a_done && w_done;
            arready = !wen && (c >= a_dly);
            awready = wen && (c >= a_dly);
            wready  = wen && (c >= w_dly);
            if (stray) begin
                rvalid = 1'($urandom); rdata = $urandom; rresp = 2'($urandom);
                bvalid = 1'($urandom); bresp = 2'($urandom);
                i_req_valid = 1'($urandom);
            end
            if (ph) begin
                if (wen) begin bvalid = (d_cnt >= d_dly); bresp = resp; end
                else begin rvalid = (d_cnt >= d_dly); rdata = rd; rresp = resp; end
                d_cnt++;
            end
            if ((arvalid && arready) || (awvalid && awready)) a_done = 1;
            if (wvalid && wready) w_done = 1;
            step();
            c++;
        end
        if (c >= 200) chk("txn_timeout", 32'd1, 32'd0);
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        for (int unsigned i = 0; i < r_dly; i++) begin
            chk("rsp_hold_valid", {31'd0, o_rsp_valid}, 32'd1);
            chk("rsp_hold_req_ready", {31'd0, o_req_ready}, 32'd0);
            if (stray) i_req_valid = 1'($urandom);
            step();
        end
        got_rd = o_rsp_rdata;
        got_err = o_rsp_err;
        i_rsp_ready = 1;
        step();
        i_rsp_ready = 0;
        i_req_valid = 0;
        chk("req_ready_after_rsp", {31'd0, o_req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd, exp_rd, ad, wd;
        logic        er, fv, wen;
        logic [1:0]  rs;
        #2;
        chk("por_req_ready", {31'd0, o_req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        step();

        do_txn(0, 32'h8000_0004, '0, '0, 0, 0, 1, 0, 32'hDEAD_BEEF, 2'b00, 0, rd, er, fv);
        chk("t1_arvalid_next", {31'd0, fv}, 32'd1);
        chk("t1_rdata", rd, 32'hDEAD_BEEF);
        chk("t1_err", {31'd0, er}, 32'd0);

        do_txn(1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 0, 0, 1, 0, '0, 2'b00, 0, rd, er, fv);
        chk("t2_aw_w_together", {31'd0, fv}, 32'd1);
        chk("t2_rdata", rd, 32'd0);
        chk("t2_err", {31'd0, er}, 32'd0);

        do_txn(1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1100, 0, 3, 0, 0, '0, 2'b00, 0, rd, er, fv);
        chk("t3_rdata", rd, 32'd0);
        chk("t3_err", {31'd0, er}, 32'd0);

        do_txn(0, 32'h8000_0030, '0, '0, 5, 0, 5, 4, 32'h5A5A_A5A5, 2'b00, 0, rd, er, fv);
        chk("t4_rdata", rd, 32'h5A5A_A5A5);

        do_txn(0, 32'h8000_0040, '0, '0, 1, 0, 0, 0, 32'h1111_2222, AXI_RESP_SLVERR, 0, rd, er, fv);
        chk("t5_rd_err", {31'd0, er}, 32'd1);
        do_txn(1, 32'h8000_0044, 32'h3, 4'hF, 0, 1, 2, 0, '0, AXI_RESP_DECERR, 0, rd, er, fv);
        chk("t5_wr_err", {31'd0, er}, 32'd1);
        do_txn(0, 32'h8000_0048, '0, '0, 0, 0, 0, 1, 32'h7777_0000, 2'b00, 0, rd, er, fv);
        chk("t5_ok_err", {31'd0, er}, 32'd0);

        i_req_valid = 1; i_req_wen = 0; i_req_addr = 32'h8000_0050;
        step();
        i_req_valid = 0; arready = 1;
        step();
        arready = 0;
        chk("t6_in_rd_d", {31'd0, rready}, 32'd1);
        #1 rst_n = 0;
        #1 chk("t6_rdd_reset", {26'd0, arvalid, rready, awvalid, wvalid, bready, o_rsp_valid}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        chk("t6_ready_after_rst", {31'd0, o_req_ready}, 32'd1);
        i_req_valid = 1; i_req_wen = 1; i_req_addr = 32'h8000_0054; i_req_wdata = 32'h99; i_req_wstrb = 4'h1;
        step();
        i_req_valid = 0;
        chk("t6_in_wr_a", {30'd0, awvalid, wvalid}, 32'd3);
        #1 rst_n = 0;
        #1 chk("t6_wra_reset", {26'd0, arvalid, rready, awvalid, wvalid, bready, o_rsp_valid}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        step();
        do_txn(0, 32'h8000_0058, '0, '0, 0, 0, 1, 0, 32'h0BAD_F00D, 2'b00, 0, rd, er, fv);
        chk("t6_fresh_rdata", rd, 32'h0BAD_F00D);
        chk("t6_fresh_err", {31'd0, er}, 32'd0);

        for (int n = 0; n < 150; n++) begin
            wen = 1'($urandom);
            ad = $urandom; wd = $urandom; exp_rd = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_txn(wen, ad, wd, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 3), exp_rd, rs, 1, rd, er, fv);
            chk("rand_rdata", rd, wen ? 32'd0 : exp_rd);
            chk("rand_err", {31'd0, er}, {31'd0, rs != 2'b00});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
